// File: rtl/p18_sprite_shift_arbiter.sv
// Shares one 1-bit sprite shift register between the SPI loader and the video renderer.
// SPI bits that arrive while the register is busy are held in a bit FIFO and written after a return to home alignment.
module p18_sprite_shift_arbiter #(
   parameter int FIFO_DEPTH  = 16,
   parameter int SPRITE_BITS = 64
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              spi_shift_req,
   input  logic                              spi_bit,
   input  logic                              disp_active,
   input  logic                              disp_shift_req,
   input  logic                              sprite_out,
   input  logic                              ovf_clear,
   output logic                              sprite_shift,
   output logic                              sprite_shift_in,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
   output logic [$clog2(SPRITE_BITS)-1:0]    rot_pos,
   output logic                              overflow,
   output logic                              busy
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH+1);
   localparam int RW = $clog2(SPRITE_BITS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DISP  = 2'd1,
      HOME  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [FIFO_DEPTH-1:0] fifo_mem;
   logic [PW-1:0]         wr_ptr, rd_ptr;
   logic                  bypass, pop, push, drop, rot_step, full;

   // The action for this cycle follows the freshly evaluated owner, so hand-over is immediate.
   always_comb begin
      state_d         = IDLE;
      sprite_shift    = 1'b0;
      sprite_shift_in = 1'b0;
      bypass          = 1'b0;
      pop             = 1'b0;
      rot_step        = 1'b0;
      if (disp_active)
         state_d = DISP;
      else if (rot_pos != '0)
         state_d = HOME;
      else if (fifo_level != '0)
         state_d = DRAIN;

      case (state_d)
         DISP: begin
            sprite_shift    = disp_shift_req;
            sprite_shift_in = sprite_out;
            rot_step        = disp_shift_req;
         end
         HOME: begin
            sprite_shift    = 1'b1;
            sprite_shift_in = sprite_out;
            rot_step        = 1'b1;
         end
         DRAIN: begin
            sprite_shift    = 1'b1;
            sprite_shift_in = fifo_mem[rd_ptr];
            pop             = 1'b1;
         end
         default: begin
            if (spi_shift_req) begin
               sprite_shift    = 1'b1;
               sprite_shift_in = spi_bit;
               bypass          = 1'b1;
            end
         end
      endcase

      full = (fifo_level == LW'(FIFO_DEPTH));
      push = spi_shift_req && !bypass && (!full || pop);
      drop = spi_shift_req && !bypass && full && !pop;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         rot_pos    <= '0;
         overflow   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (rot_step)
            rot_pos <= rot_pos + RW'(1);
         if (push) begin
            fifo_mem[wr_ptr] <= spi_bit;
            wr_ptr           <= wr_ptr + PW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)
            fifo_level <= fifo_level + LW'(1);
         else if (pop && !push)
            fifo_level <= fifo_level - LW'(1);
         // A drop in the same cycle as a clear leaves the flag set.
         if (drop)
            overflow <= 1'b1;
         else if (ovf_clear)
            overflow <= 1'b0;
      end
   end

   assign busy = (state_q != IDLE) || (fifo_level != '0);

endmodule
